// File: rtl/pkt_pkg.sv
// pkt_pkg: shared constants, state encoding and error codes for the frame parser.
package pkt_pkg;
  localparam logic [7:0] HEAD0 = 8'h55;
  localparam logic [7:0] HEAD1 = 8'hAA;
  localparam int MAX_PAY = 16;
  typedef enum logic [3:0] {ST_IDLE, ST_HEAD, ST_CMD, ST_DATA, ST_CHECK, ST_DONE, ST_DROP} state_t;
  typedef enum logic [1:0] {ERR_HEAD, ERR_SHORT, ERR_LONG, ERR_CSUM} err_t;
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return v + 16'(en && v != 16'hFFFF);
  endfunction
endpackage

// File: rtl/pkt_buf.sv
// pkt_buf: 16x8 payload register file, one write port, combinational read port.
module pkt_buf
  import pkt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] wa,
  input  logic [7:0] wd,
  input  logic [3:0] ra,
  output logic [7:0] rd
);
  logic [7:0] mem [MAX_PAY];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < MAX_PAY; i++) mem[i] <= '0;
    else if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/pkt_parse.sv
// pkt_parse: 55 AA cmd payload chk frame parser with held-frame buffer.
// Define PKT_PARSE_STAT_EN to build the good/bad/overrun statistics counters.
module pkt_parse
  import pkt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rxd,
  input  logic        rxen,
  input  logic        fs,
  output logic        fd,
  output logic [7:0]  cmd,
  output logic [4:0]  pay_len,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [3:0]  so,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] ovr_cnt
);
  state_t state, state_d;
  err_t code_d;
  logic [7:0] cand, sum, last, buf_rd;
  logic [4:0] cnt;
  logic err_d, we, commit;
  always_comb begin
    state_d = state;
    err_d = 1'b0;
    code_d = ERR_HEAD;
    we = 1'b0;
    commit = 1'b0;
    case (state)
      ST_IDLE, ST_DONE:
        if (rxen && (state == ST_IDLE || fs)) begin
          state_d = rxd == HEAD0 ? ST_HEAD : ST_DROP;
          err_d = rxd != HEAD0;
        end else if (state == ST_DONE && fs) state_d = ST_IDLE;
      ST_HEAD: begin
        state_d = !rxen ? ST_IDLE : rxd == HEAD1 ? ST_CMD : ST_DROP;
        err_d = !rxen || rxd != HEAD1;
        code_d = rxen ? ERR_HEAD : ERR_SHORT;
      end
      ST_CMD: begin
        state_d = rxen ? ST_DATA : ST_IDLE;
        err_d = !rxen;
        code_d = ERR_SHORT;
      end
      ST_DATA:
        if (!rxen) begin
          state_d = cnt == 5'd0 ? ST_IDLE : ST_CHECK;
          err_d = cnt == 5'd0;
          code_d = ERR_SHORT;
        end else if (cnt > 5'(MAX_PAY)) begin
          state_d = ST_DROP;
          err_d = 1'b1;
          code_d = ERR_LONG;
        end else we = cnt != 5'd0;
      ST_CHECK: begin
        commit = sum == last;
        state_d = commit ? ST_DONE : ST_IDLE;
        err_d = !commit;
        code_d = ERR_CSUM;
      end
      ST_DROP: state_d = rxen ? ST_DROP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_d;
  // Bytes are written one behind arrival so the trailing chk never lands in the buffer.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fd <= 1'b0;
      err <= 1'b0;
      err_code <= '0;
      cmd <= '0;
      pay_len <= '0;
      cand <= '0;
      sum <= '0;
      last <= '0;
      cnt <= '0;
    end else begin
      err <= err_d;
      if (err_d) err_code <= code_d;
      if (state == ST_CMD && rxen) begin
        cand <= rxd;
        sum <= rxd;
        cnt <= '0;
      end
      if (state == ST_DATA && rxen) begin
        last <= rxd;
        cnt <= cnt + 5'(cnt != 5'h1F);
        if (we) sum <= sum + last;
      end
      if (commit) begin
        cmd <= cand;
        pay_len <= cnt - 5'd1;
      end
      fd <= state == ST_DONE && !fs;
    end
  pkt_buf u_buf (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wa(4'(cnt - 5'd1)),
    .wd(last),
    .ra(rd_addr),
    .rd(buf_rd)
  );
  assign rd_data = {1'b0, rd_addr} < pay_len ? buf_rd : 8'h00;
  assign so = state;
`ifdef PKT_PARSE_STAT_EN
  logic rxen_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rxen_q <= 1'b0;
      good_cnt <= '0;
      bad_cnt <= '0;
      ovr_cnt <= '0;
    end else begin
      rxen_q <= rxen;
      good_cnt <= sat_inc(good_cnt, commit);
      bad_cnt <= sat_inc(bad_cnt, err_d);
      ovr_cnt <= sat_inc(ovr_cnt, state == ST_DONE && !fs && rxen && !rxen_q);
    end
`else
  assign good_cnt = '0;
  assign bad_cnt = '0;
  assign ovr_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_parse.sv
// tb_pkt_parse: randomized frames checked against a frame-level reference model.
module tb_pkt_parse;
  import pkt_pkg::*;
  typedef logic [7:0] bq_t [$];
  logic clk = 0, rst = 0, rxen = 0, fs = 0;
  logic [7:0] rxd = 0;
  logic [3:0] rd_addr = 0;
  logic fd, err;
  logic [7:0] cmd, rd_data;
  logic [4:0] pay_len;
  logic [1:0] err_code;
  logic [3:0] so;
  logic [15:0] good_cnt, bad_cnt, ovr_cnt;
  int n_cmp = 0, n_bad = 0, err_seen = 0;
  bit held = 0;
  logic [7:0] m_cmd = 0;
  logic [7:0] m_pay [$];
  int exp_code = 0, exp_good = 0, exp_bad = 0, exp_ovr = 0;

  pkt_parse dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rxen(rxen), .fs(fs), .fd(fd), .cmd(cmd),
    .pay_len(pay_len), .rd_addr(rd_addr), .rd_data(rd_data), .err(err),
    .err_code(err_code), .so(so), .good_cnt(good_cnt), .bad_cnt(bad_cnt), .ovr_cnt(ovr_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (err) err_seen++;

  // Frame classification straight from the frame rules: -1 good, else error code.
  function automatic int classify(input bq_t q);
    int s = 0;
    if (q[0] !== HEAD0) return 0;
    if (q.size() == 1) return 1;
    if (q[1] !== HEAD1) return 0;
    if (q.size() < 4) return 1;
    if (q.size() > 20) return 2;
    for (int i = 2; i < q.size() - 1; i++) s += int'(q[i]);
    return (s % 256) == int'(q[q.size() - 1]) ? -1 : 3;
  endfunction

  function automatic int predict(input bq_t q, input bit ack);
    int r;
    if (held && !ack) begin
      exp_ovr++;
      return 0;
    end
    held = 0;
    r = classify(q);
    if (r < 0) begin
      held = 1;
      m_cmd = q[2];
      m_pay.delete();
      for (int i = 3; i < q.size() - 1; i++) m_pay.push_back(q[i]);
      exp_good++;
      return 0;
    end
    exp_bad++;
    exp_code = r;
    return 1;
  endfunction

  function automatic bq_t mk(input logic [7:0] c, input int n);
    bq_t q;
    logic [7:0] s, b;
    q = {HEAD0, HEAD1, c};
    s = c;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      s += b;
    end
    q.push_back(s);
    return q;
  endfunction

  task automatic send(input bq_t q, input bit ack);
    foreach (q[i]) begin
      @(negedge clk);
      rxd = q[i];
      rxen = 1;
      fs = ack && i == 0;
    end
    @(negedge clk);
    rxen = 0;
    fs = 0;
    rxd = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_ack();
    @(negedge clk);
    fs = 1;
    @(negedge clk);
    fs = 0;
    held = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 8;
    if (fd !== 1'b0) begin n_bad++; $display("FAIL reset_fd: got %0b want 0", fd); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0b want 0", err); end
    if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", err_code); end
    if (cmd !== 8'h00) begin n_bad++; $display("FAIL reset_cmd: got %h want 00", cmd); end
    if (pay_len !== 5'd0) begin n_bad++; $display("FAIL reset_len: got %0d want 0", pay_len); end
    if (so !== 4'(ST_IDLE)) begin n_bad++; $display("FAIL reset_so: got %0d want %0d", so, ST_IDLE); end
    if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd: got %h want 00", rd_data); end
    if ({good_cnt, bad_cnt, ovr_cnt} !== 48'd0) begin n_bad++; $display("FAIL reset_stat: got %h want 0", {good_cnt, bad_cnt, ovr_cnt}); end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_good();
    bq_t q = {8'h55, 8'hAA, 8'hFF, 8'h14, 8'h86, 8'h84, 8'h33, 8'h44, 8'h55, 8'h66, 8'h3D, 8'h8C};
    int e0 = err_seen, ne;
    foreach (q[i]) begin
      @(negedge clk);
      rxd = q[i];
      rxen = 1;
    end
    @(negedge clk);
    rxen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (fd !== (k == 2)) begin n_bad++; $display("FAIL good_latency%0d: got %0b want %0b", k, fd, k == 2); end
    end
    repeat (3) @(negedge clk);
    ne = predict(q, 0);
    n_cmp += 4;
    if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL good_err: got %0d want %0d", err_seen - e0, ne); end
    if (cmd !== 8'hFF) begin n_bad++; $display("FAIL good_cmd: got %h want FF", cmd); end
    if (pay_len !== 5'd8) begin n_bad++; $display("FAIL good_len: got %0d want 8", pay_len); end
    if (fd !== 1'b1) begin n_bad++; $display("FAIL good_fd: got %0b want 1", fd); end
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      n_cmp++;
      if (rd_data !== (a < m_pay.size() ? m_pay[a] : 8'h00)) begin
        n_bad++; $display("FAIL good_rd%0d: got %h want %h", a, rd_data, a < m_pay.size() ? m_pay[a] : 8'h00);
      end
    end
    do_ack();
    @(negedge clk);
    n_cmp++;
    if (fd !== 1'b0) begin n_bad++; $display("FAIL good_ack: got %0b want 0", fd); end
  endtask

  task automatic test_head();
    bq_t q = {8'h5A, 8'hAA, 8'hE5, 8'h11, 8'h22, 8'h72};
    int e0 = err_seen, ne;
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 4;
    if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL head_err: got %0d want %0d", err_seen - e0, ne); end
    if (err_code !== 2'(exp_code)) begin n_bad++; $display("FAIL head_code: got %0d want %0d", err_code, exp_code); end
    if (fd !== 1'b0) begin n_bad++; $display("FAIL head_fd: got %0b want 0", fd); end
    if (so !== 4'(ST_IDLE)) begin n_bad++; $display("FAIL head_so: got %0d want %0d", so, ST_IDLE); end
  endtask

  task automatic test_csum();
    bq_t q = {8'h55, 8'hAA, 8'hFF, 8'h14, 8'h86, 8'h84, 8'h33, 8'h44, 8'h55, 8'h66, 8'h3D, 8'h8D};
    int e0 = err_seen, ne;
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 3;
    if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL csum_err: got %0d want %0d", err_seen - e0, ne); end
    if (err_code !== 2'(exp_code)) begin n_bad++; $display("FAIL csum_code: got %0d want %0d", err_code, exp_code); end
    if (fd !== 1'b0) begin n_bad++; $display("FAIL csum_fd: got %0b want 0", fd); end
    q = mk(8'h21, 3);
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 3;
    if (fd !== 1'b1) begin n_bad++; $display("FAIL csum_next_fd: got %0b want 1", fd); end
    if (cmd !== m_cmd) begin n_bad++; $display("FAIL csum_next_cmd: got %h want %h", cmd, m_cmd); end
    if (pay_len !== 5'(m_pay.size())) begin n_bad++; $display("FAIL csum_next_len: got %0d want %0d", pay_len, m_pay.size()); end
    do_ack();
  endtask

  task automatic test_overrun();
    bq_t q = mk(8'h3C, 5);
    int e0, ne;
    send(q, 0);
    ne = predict(q, 0);
    e0 = err_seen;
    q = mk(8'hC3, 9);
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 4;
    if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL ovr_err: got %0d want %0d", err_seen - e0, ne); end
    if (fd !== 1'b1) begin n_bad++; $display("FAIL ovr_fd: got %0b want 1", fd); end
    if (cmd !== m_cmd) begin n_bad++; $display("FAIL ovr_cmd: got %h want %h", cmd, m_cmd); end
    if (pay_len !== 5'(m_pay.size())) begin n_bad++; $display("FAIL ovr_len: got %0d want %0d", pay_len, m_pay.size()); end
    for (int a = 0; a < 6; a++) begin
      rd_addr = 4'(a);
      #1;
      n_cmp++;
      if (rd_data !== (a < m_pay.size() ? m_pay[a] : 8'h00)) begin
        n_bad++; $display("FAIL ovr_rd%0d: got %h want %h", a, rd_data, a < m_pay.size() ? m_pay[a] : 8'h00);
      end
    end
    q = mk(8'h5E, 2);
    send(q, 1);
    ne = predict(q, 1);
    n_cmp += 2;
    if (fd !== 1'b1) begin n_bad++; $display("FAIL ackhead_fd: got %0b want 1", fd); end
    if (cmd !== m_cmd) begin n_bad++; $display("FAIL ackhead_cmd: got %h want %h", cmd, m_cmd); end
    do_ack();
  endtask

  task automatic test_long_short();
    bq_t q = mk(8'h01, 18);
    int e0 = err_seen, ne;
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 2;
    if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL long_err: got %0d want %0d", err_seen - e0, ne); end
    if (err_code !== 2'(exp_code)) begin n_bad++; $display("FAIL long_code: got %0d want %0d", err_code, exp_code); end
    q = {8'h55, 8'hAA};
    e0 = err_seen;
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 2;
    if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL short_err: got %0d want %0d", err_seen - e0, ne); end
    if (err_code !== 2'(exp_code)) begin n_bad++; $display("FAIL short_code: got %0d want %0d", err_code, exp_code); end
  endtask

  task automatic test_reset_mid();
    bq_t q = mk(8'h7E, 4);
    int e0, ne;
    send(q, 0);
    ne = predict(q, 0);
    do_ack();
    q = {8'h55, 8'hAA, 8'h10, 8'h11, 8'h12, 8'h13};
    foreach (q[i]) begin
      @(negedge clk);
      rxd = q[i];
      rxen = 1;
    end
    @(negedge clk);
    rxd = 8'h14;
    n_cmp++;
    if (so !== 4'(ST_DATA)) begin n_bad++; $display("FAIL mid_so_data: got %0d want %0d", so, ST_DATA); end
    rst = 0;
    #1;
    held = 0; exp_code = 0; exp_good = 0; exp_bad = 0; exp_ovr = 0;
    e0 = err_seen;
    rd_addr = 0;
    #1;
    n_cmp += 6;
    if (fd !== 1'b0) begin n_bad++; $display("FAIL mid_fd: got %0b want 0", fd); end
    if (err_code !== 2'd0) begin n_bad++; $display("FAIL mid_code: got %0d want 0", err_code); end
    if (cmd !== 8'h00) begin n_bad++; $display("FAIL mid_cmd: got %h want 00", cmd); end
    if (pay_len !== 5'd0) begin n_bad++; $display("FAIL mid_len: got %0d want 0", pay_len); end
    if (so !== 4'(ST_IDLE)) begin n_bad++; $display("FAIL mid_so: got %0d want %0d", so, ST_IDLE); end
    if (rd_data !== 8'h00) begin n_bad++; $display("FAIL mid_rd: got %h want 00", rd_data); end
    @(negedge clk);
    rxd = 8'h15;
    @(negedge clk);
    rst = 1;
    rxd = 8'h16;
    @(negedge clk);
    rxd = 8'h17;
    @(negedge clk);
    rxen = 0;
    repeat (6) @(negedge clk);
    exp_bad++;
    n_cmp += 2;
    if (err_seen - e0 !== 1) begin n_bad++; $display("FAIL mid_tail_err: got %0d want 1", err_seen - e0); end
    if (fd !== 1'b0) begin n_bad++; $display("FAIL mid_tail_fd: got %0b want 0", fd); end
    q = mk(8'h99, 6);
    send(q, 0);
    ne = predict(q, 0);
    n_cmp += 3;
    if (fd !== 1'b1) begin n_bad++; $display("FAIL mid_next_fd: got %0b want 1", fd); end
    if (cmd !== m_cmd) begin n_bad++; $display("FAIL mid_next_cmd: got %h want %h", cmd, m_cmd); end
    rd_addr = 4'd5;
    #1;
    if (rd_data !== m_pay[5]) begin n_bad++; $display("FAIL mid_next_rd: got %h want %h", rd_data, m_pay[5]); end
  endtask

  task automatic test_random();
    bq_t q;
    int e0, ne, kind, c;
    bit ack;
    for (int it = 0; it < 60; it++) begin
      ack = 0;
      if (held) begin
        c = $urandom_range(0, 3);
        if (c == 0) do_ack();
        ack = c == 1;
      end
      kind = $urandom_range(0, 5);
      q = mk(8'($urandom), kind == 4 ? $urandom_range(17, 20) : $urandom_range(0, 16));
      if (kind == 2) q[q.size() - 1] = q[q.size() - 1] ^ 8'($urandom_range(1, 255));
      if (kind == 3) q[$urandom_range(0, 1)] = 8'h5B;
      if (kind == 5) q = q[0:$urandom_range(0, 1)];
      e0 = err_seen;
      send(q, ack);
      ne = predict(q, ack);
      n_cmp += 3;
      if (err_seen - e0 !== ne) begin n_bad++; $display("FAIL rnd%0d_err: got %0d want %0d", it, err_seen - e0, ne); end
      if (err_code !== 2'(exp_code)) begin n_bad++; $display("FAIL rnd%0d_code: got %0d want %0d", it, err_code, exp_code); end
      if (fd !== held) begin n_bad++; $display("FAIL rnd%0d_fd: got %0b want %0b", it, fd, held); end
      if (held) begin
        n_cmp += 2;
        if (cmd !== m_cmd) begin n_bad++; $display("FAIL rnd%0d_cmd: got %h want %h", it, cmd, m_cmd); end
        if (pay_len !== 5'(m_pay.size())) begin n_bad++; $display("FAIL rnd%0d_len: got %0d want %0d", it, pay_len, m_pay.size()); end
        for (int a = 0; a < 16; a++) begin
          rd_addr = 4'(a);
          #1;
          n_cmp++;
          if (rd_data !== (a < m_pay.size() ? m_pay[a] : 8'h00)) begin
            n_bad++; $display("FAIL rnd%0d_rd%0d: got %h want %h", it, a, rd_data, a < m_pay.size() ? m_pay[a] : 8'h00);
          end
        end
      end
    end
  endtask

  task automatic test_stats();
    logic [15:0] wg = 0, wb = 0, wo = 0;
`ifdef PKT_PARSE_STAT_EN
    wg = 16'(exp_good);
    wb = 16'(exp_bad);
    wo = 16'(exp_ovr);
`endif
    @(negedge clk);
    n_cmp += 3;
    if (good_cnt !== wg) begin n_bad++; $display("FAIL stat_good: got %0d want %0d", good_cnt, wg); end
    if (bad_cnt !== wb) begin n_bad++; $display("FAIL stat_bad: got %0d want %0d", bad_cnt, wb); end
    if (ovr_cnt !== wo) begin n_bad++; $display("FAIL stat_ovr: got %0d want %0d", ovr_cnt, wo); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_head();
    test_csum();
    test_overrun();
    test_long_short();
    test_reset_mid();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
